// File: rtl/mod_sub_serial_pkg.sv
// Shared definitions for the digit-serial modular subtractor:
// FSM state encodings and default datapath geometry.
package mod_sub_serial_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_ADD  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/mod_sub_serial_if.sv
// Request/response bundle for mod_sub_serial: operands in, result and status out.
interface mod_sub_serial_if #(
  parameter int WIDTH = mod_sub_serial_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             wrapped;
  logic [WIDTH-1:0] result;

  modport master (
    output start, a, b, n,
    input  busy, done, wrapped, result
  );

  modport slave (
    input  start, a, b, n,
    output busy, done, wrapped, result
  );
endinterface

// File: rtl/mod_sub_serial_digit_add_sub.sv
// One-digit adder shared by the subtract and add-back phases;
// invert_y with cin=1 turns it into a two's-complement subtractor.
module digit_add_sub #(
  parameter int DIGIT = mod_sub_serial_pkg::DEF_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  input  logic             invert_y,
  output logic [DIGIT-1:0] s,
  output logic             cout
);
  logic [DIGIT-1:0] y_eff;

  assign y_eff     = invert_y ? ~y : y;
  assign {cout, s} = {1'b0, x} + {1'b0, y_eff} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/mod_sub_serial.sv
// Digit-serial (a - b) mod n: subtract LSB digit first, then add n back
// digit by digit if the subtraction borrowed out of the top digit.
module mod_sub_serial
  import mod_sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic          clk,
  input  logic          rst_n,
  mod_sub_serial_if.slave bus
);
  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bc_q, bc_d;
  logic             wrapped_q, wrapped_d;

  logic             in_sub;
  logic             last_dig;
  logic [DIGIT-1:0] dig_x;
  logic [DIGIT-1:0] dig_y;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;

  assign in_sub   = (state_q == ST_SUB);
  assign last_dig = (cnt_q == CW'(ND - 1));

  // SUB consumes the low digits of a/b; ADD works on the rotating result and modulus.
  assign dig_x = in_sub ? a_q[DIGIT-1:0] : r_q[DIGIT-1:0];
  assign dig_y = in_sub ? b_q[DIGIT-1:0] : n_q[DIGIT-1:0];

  digit_add_sub #(.DIGIT(DIGIT)) u_add (
    .x        (dig_x),
    .y        (dig_y),
    .cin      (bc_q),
    .invert_y (in_sub),
    .s        (dig_s),
    .cout     (dig_c)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    n_d       = n_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    bc_d      = bc_q;
    wrapped_d = wrapped_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d       = bus.a;
          b_d       = bus.b;
          n_d       = bus.n;
          r_d       = '0;
          cnt_d     = '0;
          bc_d      = 1'b1;
          wrapped_d = 1'b0;
          state_d   = ST_SUB;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end

      ST_SUB: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        r_d   = {dig_s, r_q[WIDTH-1:DIGIT]};
        bc_d  = dig_c;
        cnt_d = cnt_q + 1'b1;
        if (last_dig) begin
          if (!dig_c) begin
            // Borrow out of the top digit: a < b, so fold n back in.
            bc_d    = 1'b0;
            cnt_d   = '0;
            state_d = ST_ADD;
          end else begin
            wrapped_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end

      ST_ADD: begin
        r_d   = {dig_s, r_q[WIDTH-1:DIGIT]};
        n_d   = {n_q[DIGIT-1:0], n_q[WIDTH-1:DIGIT]};
        bc_d  = dig_c;
        cnt_d = cnt_q + 1'b1;
        if (last_dig) begin
          wrapped_d = 1'b1;
          state_d   = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      bc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      n_q       <= n_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      bc_q      <= bc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.busy    = (state_q == ST_SUB) || (state_q == ST_ADD);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.wrapped = wrapped_q;
  assign bus.result  = r_q;

endmodule

// File: tb/tb_mod_sub_serial.sv
// Directed bench for mod_sub_serial: hand-computed vectors, latency,
// ignored/back-to-back starts and asynchronous reset mid-operation.
module tb_mod_sub_serial;
  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mod_sub_serial_if #(.WIDTH(W)) bus ();

  mod_sub_serial #(.WIDTH(W), .DIGIT(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a request and return #1 after the accepting edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.n     = n;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.n     = $urandom;
  endtask

  // Count edges until done is seen; returns #1 after the edge that raised done.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc      = 0;
    busy_cyc = 0;
    while (!bus.done && cyc <= 40) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!bus.done) check("done_timeout", {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] n, input logic [31:0] exp_r,
                     input logic exp_w, input int exp_lat);
    int cyc, bcyc;
    start_op(a, b, n);
    wait_done(cyc, bcyc);
    $display("[TB] %s a=%08h b=%08h n=%08h -> result=%08h wrapped=%0b latency=%0d",
             tag, a, b, n, bus.result, bus.wrapped, cyc);
    check({tag, "_result"}, bus.result, exp_r);
    check({tag, "_wrapped"}, {31'd0, bus.wrapped}, {31'd0, exp_w});
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_busy_cycles"}, bcyc, exp_lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  cyc, bcyc;
    logic saw_done;

    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.n = '0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wrapped", {31'd0, bus.wrapped}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run("basic", 32'h0000_0010, 32'h0000_0003, 32'h0000_0101, 32'h0000_000D, 1'b0, 4);
    run("wrap", 32'h0000_0003, 32'h0000_0010, 32'h0000_0101, 32'h0000_00F4, 1'b1, 8);
    run("ripple", 32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 4);
    run("equal", 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000, 1'b0, 4);
    run("wrap_top", 32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0001, 1'b1, 8);

    // A start pulse during SUB must be ignored.
    start_op(32'h0000_0010, 32'h0000_0003, 32'h0000_0101);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a = 32'h5555_5555;
    bus.b = 32'h0000_1111;
    bus.n = 32'h7777_7777;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(cyc, bcyc);
    $display("[TB] ignore_start result=%08h wrapped=%0b latency=%0d", bus.result, bus.wrapped, cyc + 2);
    check("ignore_result", bus.result, 32'h0000_000D);
    check("ignore_latency", cyc + 2, 4);

    // Back-to-back start on the done cycle.
    bus.start = 1'b1;
    bus.a = 32'h0000_0003;
    bus.b = 32'h0000_0010;
    bus.n = 32'h0000_0101;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("b2b_done_pulse", {31'd0, bus.done}, 32'd0);
    check("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(cyc, bcyc);
    $display("[TB] back_to_back result=%08h wrapped=%0b latency=%0d", bus.result, bus.wrapped, cyc);
    check("b2b_result", bus.result, 32'h0000_00F4);
    check("b2b_wrapped", {31'd0, bus.wrapped}, 32'd1);
    check("b2b_latency", cyc, 8);
    @(posedge clk);
    #1;
    check("hold_done_low", {31'd0, bus.done}, 32'd0);
    check("hold_result", bus.result, 32'h0000_00F4);
    check("hold_wrapped", {31'd0, bus.wrapped}, 32'd1);

    // Asynchronous reset in the middle of SUB.
    start_op(32'h0000_0010, 32'h0000_0003, 32'h0000_0101);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("arst_no_done", {31'd0, saw_done}, 32'd0);
    $display("[TB] async_reset mid-SUB busy=%0b done_seen=%0b result=%08h", bus.busy, saw_done, bus.result);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("after_reset", 32'h0000_0100, 32'h0000_0001, 32'h0000_1000, 32'h0000_00FF, 1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
